// File: rtl/ccff_loader_if.sv
// Host/chain side bundle for ccff_loader: word handshake from the host plus
// the serial connection to the configuration flip-flop chain.
interface ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;

    // master = host plus the chain it drives; slave = the loader
    modport master (output cfg_data, cfg_valid, ccff_tail,
                    input  cfg_ready, ccff_head, ccff_shift_en);
    modport slave  (input  cfg_data, cfg_valid, ccff_tail,
                    output cfg_ready, ccff_head, ccff_shift_en);
endinterface

// File: rtl/ccff_loader.sv
// Serialises host configuration words into a ccff chain, MSB first, with an
// optional second pass that compares the chain tail against the re-streamed bits.
module ccff_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset,
    input  logic                           start,
    input  logic                           verify,
    ccff_loader_if.slave                   bus,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_cnt
);
    localparam int NW   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST = CHAIN_LEN - (NW - 1) * WORD_W;
    localparam int BW   = $clog2(WORD_W + 1);
    localparam int RW   = $clog2(NW + 1);
    localparam int CW   = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

    state_t            state_q, state_d;
    logic              vfy_q, vfy_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              head_q, head_d;
    logic              sh_q, sh_d;
    logic              err_q, err_d;
    logic [CW-1:0]     mcnt_q, mcnt_d;
    logic              ready;
    logic              xfer;
    logic              pass_end;

    always_comb begin
        state_d = state_q;
        vfy_d   = vfy_q;
        buf_d   = buf_q;
        bcnt_d  = bcnt_q;
        rem_d   = rem_q;
        err_d   = err_q;
        mcnt_d  = mcnt_q;

        ready    = (state_q == LOAD || state_q == VERIFY) && (bcnt_q <= BW'(1)) && (rem_q != '0);
        xfer     = ready && bus.cfg_valid;
        pass_end = (rem_q == '0) && (bcnt_q == '0);

        sh_d   = (bcnt_q != '0);
        head_d = sh_d ? buf_q[WORD_W-1] : head_q;

        // A new word may land on the same edge the last buffered bit leaves
        if (xfer) begin
            buf_d  = bus.cfg_data;
            bcnt_d = (rem_q == RW'(1)) ? BW'(LAST) : BW'(WORD_W);
            rem_d  = rem_q - RW'(1);
        end else if (bcnt_q != '0) begin
            buf_d  = buf_q << 1;
            bcnt_d = bcnt_q - BW'(1);
        end

        if (state_q == VERIFY && sh_q && (bus.ccff_tail != head_q)) begin
            err_d = 1'b1;
            if (mcnt_q != CW'(CHAIN_LEN)) mcnt_d = mcnt_q + CW'(1);
        end

        // Pass ends on the cycle the last bit is on ccff_head; the chain
        // takes it at the same edge the state advances.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    vfy_d   = verify;
                    rem_d   = RW'(NW);
                    err_d   = 1'b0;
                    mcnt_d  = '0;
                end
            end
            LOAD: begin
                if (pass_end) begin
                    if (vfy_q) begin
                        state_d = VERIFY;
                        rem_d   = RW'(NW);
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            VERIFY: if (pass_end) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q <= IDLE;
            vfy_q   <= 1'b0;
            buf_q   <= '0;
            bcnt_q  <= '0;
            rem_q   <= '0;
            head_q  <= 1'b0;
            sh_q    <= 1'b0;
            err_q   <= 1'b0;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vfy_q   <= vfy_d;
            buf_q   <= buf_d;
            bcnt_q  <= bcnt_d;
            rem_q   <= rem_d;
            head_q  <= head_d;
            sh_q    <= sh_d;
            err_q   <= err_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign bus.cfg_ready     = ready;
    assign bus.ccff_head     = head_q;
    assign bus.ccff_shift_en = sh_q;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == FINISH);
    assign error             = err_q;
    assign mismatch_cnt      = mcnt_q;
endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: a 24-bit and a 20-bit instance, each driving
// a behavioural shift-register model of its chain.
module tb_ccff_loader;
    logic       prog_clk = 1'b0;
    logic       prog_reset = 1'b0;
    logic       start24 = 1'b0, start20 = 1'b0, verify = 1'b0;
    logic       busy24, done24, err24, busy20, done20, err20;
    logic [4:0] mcnt24, mcnt20;

    ccff_loader_if #(.WORD_W(8)) if24();
    ccff_loader_if #(.WORD_W(8)) if20();

    ccff_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut24 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start24), .verify(verify),
        .bus(if24), .busy(busy24), .done(done24), .error(err24), .mismatch_cnt(mcnt24));
    ccff_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start20), .verify(verify),
        .bus(if20), .busy(busy20), .done(done20), .error(err20), .mismatch_cnt(mcnt20));

    always #5 prog_clk = ~prog_clk;

    // Chain models; stuck forces flop 12 of the 24-bit chain to 0
    logic [23:0] chain24 = '0;
    logic [19:0] chain20 = '0;
    logic [23:0] eff24;
    bit          stuck = 1'b0;
    assign eff24 = stuck ? (chain24 & ~24'h001000) : chain24;
    assign if24.ccff_tail = eff24[23];
    assign if20.ccff_tail = chain20[19];
    always @(posedge prog_clk) if (if24.ccff_shift_en) chain24 <= {eff24[22:0], if24.ccff_head};
    always @(posedge prog_clk) if (if20.ccff_shift_en) chain20 <= {chain20[18:0], if20.ccff_head};

    int          cyc = 0, nsh24 = 0, nsh20 = 0, ndone24 = 0, ndone20 = 0, bad = 0;
    int          first24 = 0, last24 = 0;
    logic [23:0] cap24 = '0;
    logic [19:0] cap20 = '0;
    int          nchk = 0, nfail = 0;
    bit          abort = 1'b0;

    always @(negedge prog_clk) begin
        cyc++;
        if (if24.ccff_shift_en) begin
            if (nsh24 == 0) first24 = cyc;
            last24 = cyc;
            nsh24++;
            cap24 = {cap24[22:0], if24.ccff_head};
        end
        if (if20.ccff_shift_en) begin
            nsh20++;
            cap20 = {cap20[18:0], if20.ccff_head};
        end
        if (done24) ndone24++;
        if (done20) ndone20++;
        if (if24.ccff_shift_en && (!busy24 || done24)) bad++;
        if (if20.ccff_shift_en && (!busy20 || done20)) bad++;
    end

    typedef struct {
        logic [7:0]  w0, w1, w2;
        bit          vfy;
        bit          stk;
        int          gap;
        logic [23:0] exp_stream;
        int          exp_err;
        int          exp_mcnt;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? if20.cfg_ready : if24.cfg_ready;
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin if20.cfg_valid = v; if20.cfg_data = d; end
        else begin if24.cfg_valid = v; if24.cfg_data = d; end
    endtask

    task automatic clr();
        nsh24 = 0; nsh20 = 0; ndone24 = 0; ndone20 = 0; bad = 0;
        cap24 = '0; cap20 = '0; first24 = 0; last24 = 0;
    endtask

    task automatic pulse_start(input bit sel, input bit v);
        @(negedge prog_clk);
        if (sel) start20 = 1'b1; else start24 = 1'b1;
        verify = v;
        @(negedge prog_clk);
        start20 = 1'b0; start24 = 1'b0;
    endtask

    task automatic wait_ready(input bit sel);
        int t = 0;
        while (!rdy(sel) && !abort && t < 200) begin @(negedge prog_clk); t++; end
        if (!abort) chk("ready_wait", int'(rdy(sel)), 1);
    endtask

    task automatic send(input bit sel, input logic [7:0] w0, w1, w2, input int gap);
        logic [7:0] w[3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int i = 0; i < 3; i++) begin
            if (gap > 0 && i > 0) begin
                set_in(sel, 1'b0, 8'h00);
                wait_ready(sel);
                if (abort) return;
                repeat (gap) @(negedge prog_clk);
            end
            set_in(sel, 1'b1, w[i]);
            wait_ready(sel);
            if (abort) begin set_in(sel, 1'b0, 8'h00); return; end
            @(negedge prog_clk);
        end
        set_in(sel, 1'b0, 8'h00);
    endtask

    task automatic wait_idle(input bit sel);
        int t = 0;
        while ((sel ? busy20 : busy24) && t < 1000) begin @(negedge prog_clk); t++; end
        chk("done_wait_busy", int'(sel ? busy20 : busy24), 0);
    endtask

    task automatic run24(input vec_t v);
        clr();
        stuck = v.stk;
        pulse_start(1'b0, v.vfy);
        send(1'b0, v.w0, v.w1, v.w2, v.gap);
        if (v.vfy) send(1'b0, v.w0, v.w1, v.w2, v.gap);
        wait_idle(1'b0);
        repeat (3) @(negedge prog_clk);
        chk("stream", int'(cap24), int'(v.exp_stream));
        chk("shift_count", nsh24, v.vfy ? 48 : 24);
        chk("done_pulses", ndone24, 1);
        chk("shift_outside_pass", bad, 0);
        chk("error", int'(err24), v.exp_err);
        chk("mismatch_cnt", int'(mcnt24), v.exp_mcnt);
        if (!v.stk) chk("chain_contents", int'(chain24), int'(v.exp_stream));
        if (!v.vfy) chk("shift_span", last24 - first24 + 1, 24 + 2 * v.gap);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t;
        vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 0, 24'hA53CF0, 0, 0};
        vecs[1] = '{8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 5, 24'hA53CF0, 0, 0};
        vecs[2] = '{8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 0, 24'h123456, 0, 0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 0, 24'hFFFFFF, 1, 24};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 0, 24'h000000, 0, 0};
        set_in(1'b0, 1'b0, 8'h00);
        set_in(1'b1, 1'b0, 8'h00);

        #12;
        chk("rst_ready", int'(if24.cfg_ready), 0);
        chk("rst_head", int'(if24.ccff_head), 0);
        chk("rst_shift_en", int'(if24.ccff_shift_en), 0);
        chk("rst_busy", int'(busy24), 0);
        chk("rst_done", int'(done24), 0);
        chk("rst_error", int'(err24), 0);
        chk("rst_mcnt", int'(mcnt24), 0);
        @(negedge prog_clk);
        prog_reset = 1'b1;
        repeat (2) @(negedge prog_clk);

        foreach (vecs[i]) run24(vecs[i]);
        stuck = 1'b0;

        // Truncated last word on the 20-bit chain
        clr();
        pulse_start(1'b1, 1'b0);
        send(1'b1, 8'hFF, 8'h00, 8'hAB, 0);
        wait_idle(1'b1);
        repeat (3) @(negedge prog_clk);
        chk("c20_shift_count", nsh20, 20);
        chk("c20_stream", int'(cap20), 32'h000FF00A);
        chk("c20_last4", int'(cap20[3:0]), 4'hA);
        chk("c20_chain", int'(chain20), 32'h000FF00A);
        chk("c20_done_pulses", ndone20, 1);

        // Start with verify=1 mid-load must be ignored
        clr();
        pulse_start(1'b0, 1'b0);
        fork
            send(1'b0, 8'hA5, 8'h3C, 8'hF0, 0);
            begin
                t = 0;
                while (nsh24 < 10 && t < 200) begin @(negedge prog_clk); t++; end
                pulse_start(1'b0, 1'b1);
            end
        join
        wait_idle(1'b0);
        repeat (3) @(negedge prog_clk);
        chk("busy_start_shifts", nsh24, 24);
        chk("busy_start_done", ndone24, 1);
        chk("busy_start_stream", int'(cap24), 32'h00A53CF0);
        chk("busy_start_error", int'(err24), 0);
        verify = 1'b0;

        // Reset mid-pass aborts at once
        clr();
        n0 = 0;
        pulse_start(1'b0, 1'b0);
        fork
            send(1'b0, 8'hA5, 8'h3C, 8'hF0, 0);
            begin
                t = 0;
                while (nsh24 < 10 && t < 200) begin @(negedge prog_clk); t++; end
                #2;
                abort = 1'b1;
                prog_reset = 1'b0;
                n0 = nsh24;
                #1;
                chk("abort_shift_en", int'(if24.ccff_shift_en), 0);
                chk("abort_busy", int'(busy24), 0);
                chk("abort_ready", int'(if24.cfg_ready), 0);
                chk("abort_head", int'(if24.ccff_head), 0);
            end
        join
        repeat (2) @(negedge prog_clk);
        prog_reset = 1'b1;
        abort = 1'b0;
        repeat (5) @(negedge prog_clk);
        chk("abort_no_done", ndone24, 0);
        chk("abort_no_more_shifts", nsh24, n0);
        chk("abort_idle", int'(busy24), 0);
        run24(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
